// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory cache and its line refill engine.
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a word index within a line; a line always has at least two words.
  function automatic int line_idx_w(input int line_words);
    return (line_words <= 2) ? 1 : $clog2(line_words);
  endfunction

endpackage

// File: rtl/dmem_line_fill_if.sv
// Request/response and backing-RAM bus between data_mem, the refill engine and the block RAM.
interface dmem_line_fill_if
  import dmem_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int BRAM_AW    = 10
);

  logic                         req_valid;
  logic                         req_ready;
  logic [WORD_W-1:0]            req_fill_addr;
  logic                         req_wb;
  logic [WORD_W-1:0]            req_wb_addr;
  logic [WORD_W*LINE_WORDS-1:0] req_wb_line;
  logic [WORD_W*LINE_WORDS-1:0] fill_line;
  logic                         done;
  logic                         busy;
  logic [BRAM_AW-1:0]           mem_addr;
  logic [WORD_W-1:0]            mem_wdata;
  logic                         mem_we;
  logic                         mem_re;
  logic [WORD_W-1:0]            mem_rdata;

  // Cache and RAM side of the bus.
  modport master (
    output req_valid, req_fill_addr, req_wb, req_wb_addr, req_wb_line, mem_rdata,
    input  req_ready, fill_line, done, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

  // Refill engine side of the bus.
  modport slave (
    input  req_valid, req_fill_addr, req_wb, req_wb_addr, req_wb_line, mem_rdata,
    output req_ready, fill_line, done, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/dmem_rd_pipe.sv
// Read-return tracker: carries {valid, word index} alongside the RAM read latency so the
// capture logic knows which line slot the returning mem_rdata belongs to.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [STAGES-1:0]            vld_p;
  logic [STAGES-1:0][IDX_W-1:0] idx_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      idx_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      idx_p[0] <= in_idx;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[STAGES-1];
  assign out_idx = idx_p[STAGES-1];

endmodule

// File: rtl/dmem_line_fill.sv
// Line refill/writeback engine: optional dirty-victim writeback, then a word-by-word line
// fetch from the backing block RAM, returned to the cache as one line with a done pulse.
module dmem_line_fill
  import dmem_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int MEM_LAT    = 1,
  parameter int BRAM_AW    = 10
) (
  input logic             clk,
  input logic             rst_n,
  dmem_line_fill_if.slave bus
);

  localparam int               IDX_W    = line_idx_w(LINE_WORDS);
  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

  state_t                          state, state_nx;
  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  logic                            accept;
  logic                            wr_act;
  logic                            rd_act;
  logic                            cap_vld;
  logic [IDX_W-1:0]                cap_idx;
  logic [BRAM_AW-1:0]              fill_base;
  logic [BRAM_AW-1:0]              wb_base;
  logic [LINE_WORDS-1:0][WORD_W-1:0] wb_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0] fill_q;
  logic                            addr_unused;

  function automatic logic [BRAM_AW-1:0] line_base(input logic [BRAM_AW-1:0] word_addr);
    return word_addr & ~BRAM_AW'(LINE_WORDS - 1);
  endfunction

  assign accept = (state == IDLE) && bus.req_valid;
  assign wr_act = (state == WB);
  assign rd_act = (state == FILL) && (cnt != CNT_FULL);
  assign idx    = cnt[IDX_W-1:0];

  // Byte offset and bits above the RAM space never address a word.
  assign addr_unused = ^{bus.req_fill_addr[WORD_W-1:BRAM_AW+2], bus.req_fill_addr[1:0],
                         bus.req_wb_addr[WORD_W-1:BRAM_AW+2], bus.req_wb_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nx = bus.req_wb ? WB : FILL;
      WB:      if (cnt == CNT_LAST) state_nx = FILL;
      FILL:    if (cap_vld && (cap_idx == IDX_LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word counter restarts on every phase change; in FILL it parks at LINE_WORDS once all reads are out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (state_nx != state)    cnt <= '0;
    else if (wr_act || rd_act)     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_base <= '0;
      wb_base   <= '0;
    end else if (accept) begin
      fill_base <= line_base(bus.req_fill_addr[BRAM_AW+1:2]);
      wb_base   <= line_base(bus.req_wb_addr[BRAM_AW+1:2]);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wb_q <= bus.req_wb_line;
  end

  dmem_rd_pipe #(
    .STAGES (MEM_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_act),
    .in_idx  (idx),
    .out_vld (cap_vld),
    .out_idx (cap_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_q          <= '0;
    else if (cap_vld) fill_q[cap_idx] <= bus.mem_rdata;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (wr_act) begin
      bus.mem_addr  = wb_base + BRAM_AW'(idx);
      bus.mem_wdata = wb_q[idx];
    end else if (rd_act) begin
      bus.mem_addr  = fill_base + BRAM_AW'(idx);
    end
  end

  assign bus.mem_we    = wr_act;
  assign bus.mem_re    = rd_act;
  assign bus.done      = (state == DONE);
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.fill_line = fill_q;

endmodule

// File: tb/tb_dmem_line_fill.sv
// Bench for dmem_line_fill: a MEM_LAT=1 and a MEM_LAT=3 instance share one request stream
// and are compared against an address/data/timing model of line writeback and refill.
module tb_dmem_line_fill;

  localparam int LW = 4;
  localparam int AW = 10;

  typedef struct {
    logic [31:0]     fill_addr;
    logic            wb;
    logic [31:0]     wb_addr;
    logic [LW*32-1:0] wb_line;
  } req_t;

  typedef struct {
    req_t            q;
    logic [AW-1:0]   exp_base;
    int              exp_done1;
    int              exp_done3;
    bit              use_line;
    logic [LW*32-1:0] exp_line;
  } tbl_t;

  typedef struct {
    int               acc;
    int               done_n;
    int               done_rel;
    int               rdy_rel;
    int               rd_n;
    int               wr_n;
    logic [LW*32-1:0] line;
    logic [15:0][AW-1:0] rd_a;
    logic [15:0][7:0]    rd_t;
    logic [15:0][AW-1:0] wr_a;
    logic [15:0][31:0]   wr_d;
    logic [15:0][7:0]    wr_t;
  } rec_t;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic [31:0]      req_fill_addr;
  logic             req_wb;
  logic [31:0]      req_wb_addr;
  logic [LW*32-1:0] req_wb_line;
  int               cyc;
  int               total;
  int               bad;
  logic [31:0]      mram [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Words never written read back as a fixed function of their address.
  function automatic logic [31:0] dflt(input logic [AW-1:0] a);
    if (a >= 10'h100 && a <= 10'h103) return 32'hA0 + {22'h0, a - 10'h100};
    return ({22'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mread(input int a);
    if (mram.exists(a)) return mram[a];
    return dflt(AW'(a));
  endfunction

  function automatic int lbase(input logic [31:0] a);
    return ((int'(a >> 2)) & ((1 << AW) - 1)) / LW * LW;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int ML = (g == 0) ? 1 : 3;

    dmem_line_fill_if #(.LINE_WORDS(LW), .BRAM_AW(AW)) ifc ();

    assign ifc.req_valid     = req_valid;
    assign ifc.req_fill_addr = req_fill_addr;
    assign ifc.req_wb        = req_wb;
    assign ifc.req_wb_addr   = req_wb_addr;
    assign ifc.req_wb_line   = req_wb_line;

    dmem_line_fill #(.LINE_WORDS(LW), .MEM_LAT(ML), .BRAM_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );

    logic [31:0] mem [1<<AW];
    bit          wrn [1<<AW];
    logic [31:0] dly [ML];
    rec_t        rec;

    always @(posedge clk) begin
      if (ifc.mem_we) begin
        mem[ifc.mem_addr] <= ifc.mem_wdata;
        wrn[ifc.mem_addr] <= 1'b1;
      end
      dly[0] <= ifc.mem_re ? (wrn[ifc.mem_addr] ? mem[ifc.mem_addr] : dflt(ifc.mem_addr))
                           : $urandom;
      for (int j = 1; j < ML; j++) dly[j] <= dly[j-1];
    end

    assign ifc.mem_rdata = dly[ML-1];

    // Edge numbers are relative to the accept edge E0.
    always @(negedge clk) begin
      if (ifc.req_valid && ifc.req_ready && rst_n) begin
        rec.acc      <= cyc + 1;
        rec.done_n   <= 0;
        rec.done_rel <= -1;
        rec.rdy_rel  <= -1;
        rec.rd_n     <= 0;
        rec.wr_n     <= 0;
      end else begin
        if (ifc.mem_re && rec.rd_n < 16) begin
          rec.rd_a[rec.rd_n] <= ifc.mem_addr;
          rec.rd_t[rec.rd_n] <= 8'(cyc + 1 - rec.acc);
          rec.rd_n           <= rec.rd_n + 1;
        end
        if (ifc.mem_we && rec.wr_n < 16) begin
          rec.wr_a[rec.wr_n] <= ifc.mem_addr;
          rec.wr_d[rec.wr_n] <= ifc.mem_wdata;
          rec.wr_t[rec.wr_n] <= 8'(cyc + 1 - rec.acc);
          rec.wr_n           <= rec.wr_n + 1;
        end
        if (ifc.done) begin
          rec.done_n   <= rec.done_n + 1;
          rec.done_rel <= cyc - rec.acc;
          rec.line     <= ifc.fill_line;
        end
        if (ifc.req_ready && rec.rdy_rel < 0) rec.rdy_rel <= cyc - rec.acc;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " ready0"},  128'(g_i[0].ifc.req_ready), 128'(1));
    chk({tag, " busy0"},   128'(g_i[0].ifc.busy),      128'(0));
    chk({tag, " done0"},   128'(g_i[0].ifc.done),      128'(0));
    chk({tag, " re0"},     128'(g_i[0].ifc.mem_re),    128'(0));
    chk({tag, " we0"},     128'(g_i[0].ifc.mem_we),    128'(0));
    chk({tag, " addr0"},   128'(g_i[0].ifc.mem_addr),  128'(0));
    chk({tag, " wdata0"},  128'(g_i[0].ifc.mem_wdata), 128'(0));
    chk({tag, " line0"},   g_i[0].ifc.fill_line,       128'(0));
    chk({tag, " ready1"},  128'(g_i[1].ifc.req_ready), 128'(1));
    chk({tag, " re1"},     128'(g_i[1].ifc.mem_re),    128'(0));
    chk({tag, " we1"},     128'(g_i[1].ifc.mem_we),    128'(0));
    chk({tag, " done1"},   128'(g_i[1].ifc.done),      128'(0));
    chk({tag, " line1"},   g_i[1].ifc.fill_line,       128'(0));
  endtask

  task automatic check_inst(input string tag, input int ml, input rec_t r, input req_t q,
                            input logic [127:0] exp_line);
    int wbo, fb, wbb;
    wbo = q.wb ? LW : 0;
    fb  = lbase(q.fill_addr);
    wbb = lbase(q.wb_addr);
    chk({tag, " done_count"}, 128'(r.done_n),   128'(1));
    chk({tag, " done_edge"},  128'(r.done_rel), 128'(wbo + LW + ml));
    chk({tag, " ready_edge"}, 128'(r.rdy_rel),  128'(wbo + LW + ml + 1));
    chk({tag, " fill_line"},  r.line,           exp_line);
    chk({tag, " rd_count"},   128'(r.rd_n),     128'(LW));
    for (int i = 0; i < LW; i++) begin
      chk({tag, " rd_addr"}, 128'(r.rd_a[i]), 128'((fb + i) % (1 << AW)));
      chk({tag, " rd_edge"}, 128'(r.rd_t[i]), 128'(wbo + 1 + i));
    end
    chk({tag, " wr_count"}, 128'(r.wr_n), 128'(wbo));
    for (int i = 0; i < wbo; i++) begin
      chk({tag, " wr_addr"}, 128'(r.wr_a[i]), 128'((wbb + i) % (1 << AW)));
      chk({tag, " wr_data"}, 128'(r.wr_d[i]), 128'(q.wb_line[i*32 +: 32]));
      chk({tag, " wr_edge"}, 128'(r.wr_t[i]), 128'(1 + i));
    end
  endtask

  task automatic run_req(input req_t q, input bit poke);
    logic [127:0] exp_line;
    int fb, wbb;
    @(posedge clk); #1;
    req_valid     = 1'b1;
    req_fill_addr = q.fill_addr;
    req_wb        = q.wb;
    req_wb_addr   = q.wb_addr;
    req_wb_line   = q.wb_line;
    @(posedge clk); #1;
    req_valid     = 1'b0;
    req_fill_addr = 32'h0000_0800;
    req_wb        = 1'b1;
    req_wb_addr   = $urandom;
    req_wb_line   = {$urandom, $urandom, $urandom, $urandom};
    fb  = lbase(q.fill_addr);
    wbb = lbase(q.wb_addr);
    if (q.wb)
      for (int i = 0; i < LW; i++) mram[(wbb + i) % (1 << AW)] = q.wb_line[i*32 +: 32];
    for (int i = 0; i < LW; i++) exp_line[i*32 +: 32] = mread((fb + i) % (1 << AW));
    for (int k = 0; k < 80; k++) begin
      if (poke) req_valid = (k == 1 || k == 2);
      @(posedge clk); #1;
      if (k > 2 && g_i[0].rec.done_n > 0 && g_i[1].rec.done_n > 0 &&
          g_i[0].ifc.req_ready && g_i[1].ifc.req_ready) break;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_inst("lat1", 1, g_i[0].rec, q, exp_line);
    check_inst("lat3", 3, g_i[1].rec, q, exp_line);
    chk("lat1 line_hold", g_i[0].ifc.fill_line, exp_line);
    chk("lat3 line_hold", g_i[1].ifc.fill_line, exp_line);
    chk("lat1 idle_busy", 128'(g_i[0].ifc.busy), 128'(0));
    chk("lat3 idle_busy", 128'(g_i[1].ifc.busy), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl_t tbl [6];
    req_t q;

    tbl[0] = '{'{32'h0000_0400, 1'b0, 32'h0, 128'h0}, 10'h100, 5, 7, 1'b1,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    tbl[1] = '{'{32'h0000_0400, 1'b1, 32'h0000_0040, {32'h4, 32'h3, 32'h2, 32'hDEAD_BEEF}},
               10'h100, 9, 11, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    tbl[2] = '{'{32'h0000_0080, 1'b1, 32'h0000_0080, {32'h11, 32'h22, 32'h33, 32'h44}},
               10'h020, 9, 11, 1'b1, {32'h11, 32'h22, 32'h33, 32'h44}};
    tbl[3] = '{'{32'h0000_0FF0, 1'b0, 32'h0, 128'h0}, 10'h3FC, 5, 7, 1'b0, 128'h0};
    tbl[4] = '{'{32'h0000_1000, 1'b0, 32'h0, 128'h0}, 10'h000, 5, 7, 1'b0, 128'h0};
    tbl[5] = '{'{32'hABCD_0404, 1'b1, 32'hFFFF_FFF0, {32'h1357, 32'h2468, 32'hCAFE, 32'hF00D}},
               10'h100, 9, 11, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};

    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_fill_addr = '0;
    req_wb        = 1'b0;
    req_wb_addr   = '0;
    req_wb_line   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_rst("por");
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_req(tbl[t].q, 1'b0);
      chk("tbl first_read", 128'(g_i[0].rec.rd_a[0]), 128'(tbl[t].exp_base));
      chk("tbl done_lat1",  128'(g_i[0].rec.done_rel), 128'(tbl[t].exp_done1));
      chk("tbl done_lat3",  128'(g_i[1].rec.done_rel), 128'(tbl[t].exp_done3));
      if (tbl[t].use_line) begin
        chk("tbl line_lat1", g_i[0].rec.line, tbl[t].exp_line);
        chk("tbl line_lat3", g_i[1].rec.line, tbl[t].exp_line);
      end
    end
    chk("ram word 0x10", 128'(g_i[0].mem[16]), 128'(32'hDEAD_BEEF));

    q = '{32'h0000_040C, 1'b0, 32'h0, 128'h0};
    run_req(q, 1'b1);
    chk("busy_req line", g_i[0].rec.line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    for (int n = 0; n < 30; n++) begin
      q.fill_addr = $urandom;
      q.wb        = 1'($urandom_range(0, 1));
      q.wb_addr   = ($urandom_range(0, 3) == 0) ? q.fill_addr : $urandom;
      q.wb_line   = {$urandom, $urandom, $urandom, $urandom};
      run_req(q, 1'b0);
    end

    @(posedge clk); #1;
    req_valid     = 1'b1;
    req_fill_addr = 32'h0000_0400;
    req_wb        = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rst("mid_rst assert");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_rst("mid_rst hold");
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_rst("mid_rst after");
    chk("mid_rst no_done lat1", 128'(g_i[0].rec.done_n), 128'(0));
    chk("mid_rst no_done lat3", 128'(g_i[1].rec.done_n), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
